// File: rtl/divider_seq_disp_board.sv
// Sequential restoring divider (one quotient bit per clock, signed/unsigned) with
// divide-by-zero flag, multiplexed hex seven-segment display and status LEDs.
module divider_seq_disp_board #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [WIDTH-1:0]  divisor,
  input  logic              signed_mode,
  input  logic              show_rem,
  output logic              done,
  output logic              busy,
  output logic              div_zero,
  output logic [6:0]        out,
  output logic [DIGITS-1:0] an,
  output logic              led1,
  output logic              led2,
  output logic              led3,
  output logic              led4
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [DW-1:0] LAST_DIG  = DW'(DIGITS - 1);
  localparam logic [SW-1:0] LAST_SCAN = SW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  logic               r_start_d;
  logic               r_done, r_busy, r_dz;
  logic               r_led1, r_led2, r_led3, r_led4;
  logic [WIDTH-1:0]   r_q, r_r;
  logic [WIDTH-1:0]   r_dq;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_q, r_neg_r;

  logic [SW-1:0]      r_scan;
  logic [DW-1:0]      r_digit;
  logic [6:0]         r_out;
  logic [DIGITS-1:0]  r_an;

  logic               w_accept;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_fits;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_q_fix, w_r_fix;
  logic [WIDTH-1:0]   w_sel;
  logic [3:0]         w_nib;
  logic [6:0]         w_seg;

  assign w_accept = r_start_d & ~start & ((r_state == S_IDLE) | (r_state == S_DONE));

  assign w_a_neg  = signed_mode & dividend[WIDTH-1];
  assign w_b_neg  = signed_mode & divisor[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -dividend : dividend;
  assign w_abs_b  = w_b_neg ? -divisor  : divisor;

  // Remainder stays below the divisor, so only the shifted value needs WIDTH+1 bits
  // and the difference is exact modulo 2^WIDTH.
  assign w_rem_sh = {r_rem, r_dq[WIDTH-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - r_dvs;

  assign w_q_fix  = r_neg_q ? -r_dq  : r_dq;
  assign w_r_fix  = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_start_d <= 1'b1;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_dz      <= 1'b0;
      r_led1    <= 1'b0;
      r_led2    <= 1'b0;
      r_led3    <= 1'b0;
      r_led4    <= 1'b0;
      r_q       <= '0;
      r_r       <= '0;
      r_dq      <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      r_start_d <= start;
      case (r_state)
        S_IDLE, S_DONE: begin
          // Flags drop on the accepting edge so done and busy never overlap.
          if (w_accept) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_led1  <= 1'b1;
            r_done  <= 1'b0;
            r_led2  <= 1'b0;
            r_dz    <= 1'b0;
            r_led3  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_dq    <= w_abs_a;
          r_dvs   <= w_abs_b;
          r_rem   <= '0;
          r_cnt   <= '0;
          if (divisor == '0) begin
            r_q     <= '1;
            r_r     <= dividend;
            r_led4  <= 1'b1;
            r_dz    <= 1'b1;
            r_led3  <= 1'b1;
            r_done  <= 1'b1;
            r_led2  <= 1'b1;
            r_busy  <= 1'b0;
            r_led1  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_fits ? w_diff : w_rem_sh[WIDTH-1:0];
          r_dq  <= {r_dq[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) r_state <= S_FIX;
        end
        S_FIX: begin
          r_q     <= w_q_fix;
          r_r     <= w_r_fix;
          r_led4  <= w_q_fix[WIDTH-1];
          r_done  <= 1'b1;
          r_led2  <= 1'b1;
          r_busy  <= 1'b0;
          r_led1  <= 1'b0;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_sel = show_rem ? r_r : r_q;
  assign w_nib = 4'(w_sel >> {r_digit, 2'b00});

  always_comb begin
    w_seg = 7'b1111111;
    case (w_nib)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      4'hF: w_seg = 7'b0001110;
      default: w_seg = 7'b1111111;
    endcase
  end

  // Segment and anode registers both follow r_digit, so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan  <= '0;
      r_digit <= '0;
      r_out   <= 7'b1000000;
      r_an    <= ~DIGITS'(1);
    end else begin
      if (r_scan == LAST_SCAN) begin
        r_scan  <= '0;
        r_digit <= (r_digit == LAST_DIG) ? '0 : r_digit + 1'b1;
      end else begin
        r_scan  <= r_scan + 1'b1;
      end
      r_out <= w_seg;
      r_an  <= ~(DIGITS'(1) << r_digit);
    end
  end

  assign done     = r_done;
  assign busy     = r_busy;
  assign div_zero = r_dz;
  assign out      = r_out;
  assign an       = r_an;
  assign led1     = r_led1;
  assign led2     = r_led2;
  assign led3     = r_led3;
  assign led4     = r_led4;

endmodule
